// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two valid/ready requesters.
// Optional response timeout is enabled by defining ALU_ARBITER_TIMEOUT_EN.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a request; grants one port and latches operands
// EXEC  | ALU settles on registered operands; result captured at edge
// RESP  | result presented to owner until it accepts (or times out)
module alu_arbiter #(
  parameter int W           = 4,
  parameter int RSP_TIMEOUT = 255
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [W-1:0]   req0_op1,
  input  logic [W-1:0]   req0_op2,
  input  logic [2:0]     req0_opcode,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [W-1:0]   req1_op1,
  input  logic [W-1:0]   req1_op2,
  input  logic [2:0]     req1_opcode,
  output logic           rsp0_valid,
  input  logic           rsp0_ready,
  output logic           rsp1_valid,
  input  logic           rsp1_ready,
  output logic [W+3:0]   rsp_result,
  output logic [W-1:0]   alu_op1,
  output logic [W-1:0]   alu_op2,
  output logic [2:0]     alu_opcode,
  input  logic [W-1:0]   alu_out,
  input  logic           alu_carry,
  input  logic           alu_overflow,
  input  logic           alu_compare,
  input  logic           alu_equal,
  output logic           busy,
  output logic           last_grant
`ifdef ALU_ARBITER_TIMEOUT_EN
  ,
  output logic           timeout_err
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   owner;
  logic   rr_ptr;
  logic   req_any;
  logic   grant_port;
  logic   rsp_hs;
  logic   leave_resp;

`ifdef ALU_ARBITER_TIMEOUT_EN
  localparam int CW = (RSP_TIMEOUT > 1) ? $clog2(RSP_TIMEOUT) : 1;
  logic [CW-1:0] wait_cnt;
  logic          rsp_drop;
`endif

  assign req_any    = req0_valid | req1_valid;
  // Contention resolves by rr_ptr; a lone requester wins regardless of it.
  assign grant_port = (req0_valid & req1_valid) ? rr_ptr : req1_valid;
  assign rsp_hs     = owner ? rsp1_ready : rsp0_ready;
  assign busy       = (state != IDLE);
  assign last_grant = owner;

  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    leave_resp = 1'b0;
`ifdef ALU_ARBITER_TIMEOUT_EN
    rsp_drop   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (req_any) begin
          req0_ready = ~grant_port;
          req1_ready = grant_port;
          state_nxt  = EXEC;
        end
      end
      EXEC: begin
        state_nxt = RESP;
      end
      RESP: begin
        rsp0_valid = ~owner;
        rsp1_valid = owner;
        if (rsp_hs) begin
          leave_resp = 1'b1;
          state_nxt  = IDLE;
        end
`ifdef ALU_ARBITER_TIMEOUT_EN
        else if (wait_cnt == '0) begin
          leave_resp = 1'b1;
          rsp_drop   = 1'b1;
          state_nxt  = IDLE;
        end
`endif
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      rr_ptr     <= 1'b0;
      alu_op1    <= '0;
      alu_op2    <= '0;
      alu_opcode <= '0;
      rsp_result <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && req_any) begin
        owner      <= grant_port;
        alu_op1    <= grant_port ? req1_op1    : req0_op1;
        alu_op2    <= grant_port ? req1_op2    : req0_op2;
        alu_opcode <= grant_port ? req1_opcode : req0_opcode;
      end
      if (state == EXEC) begin
        rsp_result <= {alu_overflow, alu_carry, alu_equal, alu_compare, alu_out};
      end
      if (leave_resp) begin
        rr_ptr <= ~owner;
      end
    end
  end

`ifdef ALU_ARBITER_TIMEOUT_EN
  // Down-counter loaded on RESP entry; terminal count at zero ends the wait.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == EXEC) begin
        wait_cnt <= CW'(RSP_TIMEOUT - 1);
      end else if (state == RESP && wait_cnt != '0) begin
        wait_cnt <= wait_cnt - 1'b1;
      end
      if (rsp_drop) begin
        timeout_err <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with a small behavioural 4-bit ALU.
module tb_alu_arbiter;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [W-1:0] req0_op1, req0_op2, req1_op1, req1_op2;
  logic [2:0]   req0_opcode, req1_opcode;
  logic         rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [W+3:0] rsp_result;
  logic [W-1:0] alu_op1, alu_op2, alu_out;
  logic [2:0]   alu_opcode;
  logic         alu_carry, alu_overflow, alu_compare, alu_equal;
  logic         busy, last_grant;
`ifdef ALU_ARBITER_TIMEOUT_EN
  logic         timeout_err;
`endif
  logic [W:0]   sum, diff;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.W(W), .RSP_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_op1(req0_op1), .req0_op2(req0_op2), .req0_opcode(req0_opcode),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_op1(req1_op1), .req1_op2(req1_op2), .req1_opcode(req1_opcode),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_opcode(alu_opcode),
    .alu_out(alu_out), .alu_carry(alu_carry), .alu_overflow(alu_overflow),
    .alu_compare(alu_compare), .alu_equal(alu_equal),
    .busy(busy), .last_grant(last_grant)
`ifdef ALU_ARBITER_TIMEOUT_EN
    , .timeout_err(timeout_err)
`endif
  );

  // Environment ALU: 0 add, 1 sub, 2 and, 3 or, 4 xor, else pass op1.
  always_comb begin
    sum          = {1'b0, alu_op1} + {1'b0, alu_op2};
    diff         = {1'b0, alu_op1} - {1'b0, alu_op2};
    alu_carry    = 1'b0;
    alu_overflow = 1'b0;
    case (alu_opcode)
      3'd0: begin
        alu_out      = sum[W-1:0];
        alu_carry    = sum[W];
        alu_overflow = (alu_op1[W-1] == alu_op2[W-1]) && (sum[W-1] != alu_op1[W-1]);
      end
      3'd1: begin
        alu_out      = diff[W-1:0];
        alu_carry    = diff[W];
        alu_overflow = (alu_op1[W-1] != alu_op2[W-1]) && (diff[W-1] != alu_op1[W-1]);
      end
      3'd2:    alu_out = alu_op1 & alu_op2;
      3'd3:    alu_out = alu_op1 | alu_op2;
      3'd4:    alu_out = alu_op1 ^ alu_op2;
      default: alu_out = alu_op1;
    endcase
    alu_compare = (alu_op1 > alu_op2);
    alu_equal   = (alu_op1 == alu_op2);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Port 0: and 4,4 -> out 4, equal -> 8'h24.  Port 1: sub 7,2 -> out 5, compare -> 8'h15.
  logic [7:0] exp_rsp [2];

  initial begin
    exp_rsp[0] = 8'h24;
    exp_rsp[1] = 8'h15;
    rst = 1'b1;
    req0_valid = 0; req0_op1 = 0; req0_op2 = 0; req0_opcode = 0;
    req1_valid = 0; req1_op1 = 0; req1_op2 = 0; req1_opcode = 0;
    rsp0_ready = 0; rsp1_ready = 0;
    cyc(); cyc();
    rst = 1'b0;

    // Reset and idle
    repeat (10) cyc();
    check("idle_req0_ready", req0_ready, 0);
    check("idle_req1_ready", req1_ready, 0);
    check("idle_rsp0_valid", rsp0_valid, 0);
    check("idle_rsp1_valid", rsp1_valid, 0);
    check("idle_busy", busy, 0);
    check("idle_rsp_result", rsp_result, 0);
    check("idle_alu_op1", alu_op1, 0);
    check("idle_alu_op2", alu_op2, 0);
    check("idle_alu_opcode", alu_opcode, 0);
    check("idle_last_grant", last_grant, 0);

    // Single add 3+5 on port 0
    rsp0_ready = 1;
    req0_valid = 1; req0_op1 = 4'd3; req0_op2 = 4'd5; req0_opcode = 3'd0;
    #1;
    check("add_c0_req0_ready", req0_ready, 1);
    check("add_c0_req1_ready", req1_ready, 0);
    check("add_c0_busy", busy, 0);
    cyc();
    req0_valid = 0;
    #1;
    check("add_c1_busy", busy, 1);
    check("add_c1_rsp0_valid", rsp0_valid, 0);
    check("add_c1_req0_ready", req0_ready, 0);
    check("add_c1_alu_op1", alu_op1, 3);
    check("add_c1_alu_op2", alu_op2, 5);
    cyc();
    check("add_c2_rsp0_valid", rsp0_valid, 1);
    check("add_c2_rsp1_valid", rsp1_valid, 0);
    check("add_c2_rsp_result", rsp_result, 8'h88);
    check("add_c2_busy", busy, 1);
    check("add_c2_last_grant", last_grant, 0);
    cyc();
    check("add_c3_busy", busy, 0);
    check("add_c3_rsp0_valid", rsp0_valid, 0);

    // Round-robin from a fresh reset
    rst = 1; cyc(); rst = 0;
    rsp0_ready = 1; rsp1_ready = 1;
    req0_op1 = 4'd4; req0_op2 = 4'd4; req0_opcode = 3'd2;
    req1_op1 = 4'd7; req1_op2 = 4'd2; req1_opcode = 3'd1;
    req0_valid = 1; req1_valid = 1;
    #1;
    for (int t = 0; t < 6; t++) begin
      int e;
      e = t % 2;
      check("rr_req0_ready", req0_ready, (e == 0));
      check("rr_req1_ready", req1_ready, (e == 1));
      cyc();
      check("rr_last_grant", last_grant, e);
      check("rr_busy_exec", busy, 1);
      cyc();
      check("rr_rsp0_valid", rsp0_valid, (e == 0));
      check("rr_rsp1_valid", rsp1_valid, (e == 1));
      check("rr_rsp_result", rsp_result, exp_rsp[e]);
      cyc();
    end

    // Port 1 response stalled for 20 cycles with port 0 waiting
    req0_valid = 0; rsp1_ready = 0;
    #1;
    check("stall_req1_ready", req1_ready, 1);
    cyc();
    req1_valid = 0; req0_valid = 1;
    #1;
    check("stall_exec_req0_ready", req0_ready, 0);
    cyc();
    for (int i = 0; i < 20; i++) begin
      check("stall_rsp1_valid", rsp1_valid, 1);
      check("stall_rsp0_valid", rsp0_valid, 0);
      check("stall_rsp_result", rsp_result, 8'h15);
      check("stall_req0_ready", req0_ready, 0);
      cyc();
    end
    rsp1_ready = 1;
    #1;
    check("stall_release_rsp1_valid", rsp1_valid, 1);
    cyc();
    check("stall_after_rsp1_valid", rsp1_valid, 0);
    check("stall_after_busy", busy, 0);
    check("stall_after_req0_ready", req0_ready, 1);
    cyc();
    req0_valid = 0;
    check("stall_req0_grant", last_grant, 0);
    cyc();
    check("stall_req0_rsp_valid", rsp0_valid, 1);
    check("stall_req0_rsp_result", rsp_result, 8'h24);
    cyc();

    // Reset during EXEC of a port 1 transaction (rr_ptr is 1 here)
    req1_valid = 1;
    #1;
    check("rst_req1_ready", req1_ready, 1);
    cyc();
    req1_valid = 0; rst = 1;
    check("rst_exec_busy", busy, 1);
    cyc();
    rst = 0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_rsp0_valid", rsp0_valid, 0);
    check("rst_rsp1_valid", rsp1_valid, 0);
    check("rst_rsp_result", rsp_result, 0);
    check("rst_last_grant", last_grant, 0);
    check("rst_alu_op1", alu_op1, 0);
    cyc();
    check("rst_no_pulse_rsp1", rsp1_valid, 0);
    req0_valid = 1; req1_valid = 1;
    #1;
    check("rst_rr_req0_ready", req0_ready, 1);
    check("rst_rr_req1_ready", req1_ready, 0);
    cyc();
    req0_valid = 0; req1_valid = 0;
    check("rst_rr_last_grant", last_grant, 0);
    repeat (3) cyc();
    check("drain_busy", busy, 0);

`ifdef ALU_ARBITER_TIMEOUT_EN
    // Response timeout after 4 RESP cycles, sticky error
    rsp0_ready = 0;
    req0_valid = 1;
    #1;
    check("to_err_init", timeout_err, 0);
    cyc();
    req0_valid = 0;
    cyc();
    for (int i = 0; i < 4; i++) begin
      check("to_rsp0_valid", rsp0_valid, 1);
      cyc();
    end
    check("to_dropped", rsp0_valid, 0);
    check("to_busy", busy, 0);
    check("to_err_set", timeout_err, 1);
    rsp0_ready = 1; req0_valid = 1;
    cyc();
    req0_valid = 0;
    cyc();
    check("to_good_rsp0_valid", rsp0_valid, 1);
    cyc();
    check("to_err_sticky", timeout_err, 1);
    rst = 1; cyc(); rst = 0;
    #1;
    check("to_err_cleared", timeout_err, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
